// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared bus widths, master indices and round-robin helper
//
// Purpose: constants shared between the bus arbiter and the nes top level.
// Ports:   none (package).

package bus_arbiter_pkg;

    localparam int NES_ADDR_WIDTH = 16;
    localparam int NES_DATA_WIDTH = 8;

    localparam int MASTER_DBG = 0;
    localparam int MASTER_CPU = 1;
    localparam int MASTER_DMA = 2;

    // Next round-robin position after idx; master 0 never takes part in the
    // rotation, so the pointer wraps from num_masters-1 back to 1.
    function automatic int rr_next(input int idx, input int num_masters);
        return (idx + 1 >= num_masters) ? 1 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational find-first-set with rotating base
//
// Purpose: returns the first set bit of req at or above base, wrapping at WIDTH.
// Ports:
//   req   in  WIDTH  candidate request vector
//   base  in  IDX_W  starting search position
//   found out 1      any bit of req set
//   idx   out IDX_W  position of the first set bit (0 when found=0)

module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] base,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < WIDTH; i++) begin
            pos = (int'(base) + i) % WIDTH;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - N-master request/grant arbiter for the CPU memory-controller bus
//
// Purpose: master 0 (debugger) has absolute priority; masters 1..N-1 share
// the bus round-robin with a bounded hold time. Read data valid strobes are
// tagged with the issuing master so they survive a grant change.
// Ports:
//   clk       in   1                      system clock
//   rst       in   1                      asynchronous active-low reset
//   m_req     in   NUM_MASTERS            per-master level request
//   m_a       in   NUM_MASTERS*ADDR_WIDTH per-master address
//   m_r_nw    in   NUM_MASTERS            per-master read/!write
//   m_dout    in   NUM_MASTERS*DATA_WIDTH per-master write data
//   m_gnt     out  NUM_MASTERS            one-hot registered grant
//   m_rvalid  out  NUM_MASTERS            per-master read data valid
//   m_din     out  DATA_WIDTH             read data broadcast
//   s_a       out  ADDR_WIDTH             slave address
//   s_r_nw    out  1                      slave read/!write (1 when idle)
//   s_din     out  DATA_WIDTH             slave write data
//   s_dout    in   DATA_WIDTH             slave read data
//   owner     out  clog2(NUM_MASTERS)     binary index of grantee
//   busy      out  1                      grant active

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_WIDTH  = NES_ADDR_WIDTH,
    parameter int DATA_WIDTH  = NES_DATA_WIDTH,
    parameter int MAX_HOLD    = 16,
    parameter int RD_LATENCY  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a,
    input  logic [NUM_MASTERS-1:0]            m_r_nw,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dout,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [DATA_WIDTH-1:0]             m_din,
    output logic [ADDR_WIDTH-1:0]             s_a,
    output logic                              s_r_nw,
    output logic [DATA_WIDTH-1:0]             s_din,
    input  logic [DATA_WIDTH-1:0]             s_dout,
    output logic [$clog2(NUM_MASTERS)-1:0]    owner,
    output logic                              busy
);

    localparam int OW = $clog2(NUM_MASTERS);
    localparam int HW = $clog2(MAX_HOLD) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [OW-1:0] IDX_DBG   = OW'(MASTER_DBG);
    localparam logic [OW-1:0] IDX_RR0   = OW'(MASTER_CPU);

    logic [0:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]          hold_q, hold_d;

    logic [RD_LATENCY-1:0][NUM_MASTERS-1:0] rv_q, rv_d;

    logic                   rr_owned;
    logic [OW-1:0]          next_owner;
    logic [NUM_MASTERS-1:0] pick_req;
    logic [OW-1:0]          pick_base;
    logic                   pick_found;
    logic [OW-1:0]          pick_idx;
    logic                   grant_change;
    logic [OW-1:0]          new_idx;

    // A round-robin master (index >= 1) currently holds the bus.
    assign rr_owned   = (state_q == ST_OWNED) && (owner_q != IDX_DBG);
    assign next_owner = OW'(rr_next(int'(owner_q), NUM_MASTERS));

    // The picker only ever sees round-robin candidates. While a round-robin
    // master owns the bus it is masked out and the search starts just past
    // it: on release its request is already low, and on a hold expiry this
    // hands the bus to the next waiting master.
    always_comb begin
        pick_req    = m_req;
        pick_req[0] = 1'b0;
        pick_base   = rr_ptr_q;
        if (rr_owned) begin
            pick_req  = pick_req & ~gnt_q;
            pick_base = next_owner;
        end
    end

    rr_pick #(
        .WIDTH (NUM_MASTERS),
        .IDX_W (OW)
    ) u_rr_pick (
        .req   (pick_req),
        .base  (pick_base),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        hold_d       = hold_q;
        grant_change = 1'b0;
        new_idx      = '0;

        case (state_q)
            ST_IDLE: begin
                if (m_req[0]) begin
                    grant_change = 1'b1;
                    new_idx      = IDX_DBG;
                end else if (pick_found) begin
                    grant_change = 1'b1;
                    new_idx      = pick_idx;
                end
            end
            ST_OWNED: begin
                if (!m_req[owner_q]) begin
                    // Release, with rearbitration on the same edge.
                    if (owner_q != IDX_DBG) begin
                        rr_ptr_d = next_owner;
                    end
                    if (m_req[0]) begin
                        grant_change = 1'b1;
                        new_idx      = IDX_DBG;
                    end else if (pick_found) begin
                        grant_change = 1'b1;
                        new_idx      = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        owner_d = '0;
                        hold_d  = '0;
                    end
                end else if (rr_owned && m_req[0]) begin
                    // Debugger preemption; the preempted master keeps
                    // requesting and is re-granted later.
                    grant_change = 1'b1;
                    new_idx      = IDX_DBG;
                end else if (rr_owned && (hold_q == HOLD_LAST) && pick_found) begin
                    grant_change = 1'b1;
                    new_idx      = pick_idx;
                    rr_ptr_d     = next_owner;
                end else if (rr_owned && (hold_q != HOLD_LAST)) begin
                    // Saturates so a lone requester keeps the bus forever.
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                owner_d = '0;
                hold_d  = '0;
            end
        endcase

        if (grant_change) begin
            state_d        = ST_OWNED;
            gnt_d          = '0;
            gnt_d[new_idx] = 1'b1;
            owner_d        = new_idx;
            hold_d         = '0;
        end
    end

    // Slave side follows the owner combinationally; idle is always a read
    // of address 0 so the bus never idles as a write.
    always_comb begin
        s_a    = '0;
        s_r_nw = 1'b1;
        s_din  = '0;
        if (state_q == ST_OWNED) begin
            s_a    = m_a[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
            s_r_nw = m_r_nw[owner_q];
            s_din  = m_dout[owner_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Each issued read carries the one-hot grant of its issuer down the
    // pipeline, so the strobe reaches the right master after a handoff.
    always_comb begin
        rv_d    = '0;
        rv_d[0] = ((state_q == ST_OWNED) && s_r_nw) ? gnt_q : '0;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rv_d[i] = rv_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= IDX_RR0;
            hold_q   <= '0;
            rv_q     <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            rv_q     <= rv_d;
        end
    end

    assign m_gnt    = gnt_q;
    assign owner    = owner_q;
    assign busy     = |gnt_q;
    assign m_rvalid = rv_q[RD_LATENCY-1];
    assign m_din    = s_dout;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter

module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int NM = 3;
    localparam int AW = 16;
    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic [NM-1:0]   m_req;
    logic [NM*AW-1:0] m_a;
    logic [NM-1:0]   m_r_nw;
    logic [NM*DW-1:0] m_dout;
    logic [NM-1:0]   m_gnt;
    logic [NM-1:0]   m_rvalid;
    logic [DW-1:0]   m_din;
    logic [AW-1:0]   s_a;
    logic            s_r_nw;
    logic [DW-1:0]   s_din;
    logic [DW-1:0]   s_dout;
    logic [1:0]      owner;
    logic            busy;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_HOLD    (4),
        .RD_LATENCY  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_a      (m_a),
        .m_r_nw   (m_r_nw),
        .m_dout   (m_dout),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_din    (m_din),
        .s_a      (s_a),
        .s_r_nw   (s_r_nw),
        .s_din    (s_din),
        .s_dout   (s_dout),
        .owner    (owner),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave with 1-cycle synchronous read: data = low address byte ^ 0xA5.
    initial s_dout = '0;
    always @(posedge clk) begin
        if (s_r_nw) s_dout <= s_a[7:0] ^ 8'hA5;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b0;
        m_req  = '0;
        m_a    = '0;
        m_r_nw = '0;
        m_dout = '0;
        tick();
        tick();

        // Reset state
        check("rst_gnt", 32'(m_gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_rvalid", 32'(m_rvalid), 32'h0);
        check("rst_s_r_nw", 32'(s_r_nw), 32'h1);
        check("rst_s_a", 32'(s_a), 32'h0);
        check("rst_s_din", 32'(s_din), 32'h0);
        rst = 1'b1;
        tick();
        check("idle_gnt", 32'(m_gnt), 32'h0);

        // Single CPU read
        m_req = 3'b010;
        m_a[MASTER_CPU*AW +: AW] = 16'h0123;
        m_r_nw[MASTER_CPU] = 1'b1;
        tick();
        check("rd_gnt", 32'(m_gnt), 32'h2);
        check("rd_busy", 32'(busy), 32'h1);
        check("rd_owner", 32'(owner), 32'h1);
        check("rd_s_a", 32'(s_a), 32'h0123);
        check("rd_s_r_nw", 32'(s_r_nw), 32'h1);
        check("rd_rvalid0", 32'(m_rvalid), 32'h0);
        tick();
        check("rd_rvalid1", 32'(m_rvalid), 32'h2);
        check("rd_din", 32'(m_din), 32'h86);
        m_req = 3'b000;
        m_r_nw[MASTER_CPU] = 1'b0;
        tick();
        check("rel_gnt", 32'(m_gnt), 32'h0);
        check("rel_busy", 32'(busy), 32'h0);
        check("rel_rvalid", 32'(m_rvalid), 32'h0);
        check("rel_s_r_nw", 32'(s_r_nw), 32'h1);

        // Debugger preemption of a CPU write stream
        m_req = 3'b010;
        m_a[MASTER_CPU*AW +: AW] = 16'h0200;
        m_dout[MASTER_CPU*DW +: DW] = 8'h55;
        m_a[MASTER_DBG*AW +: AW] = 16'h0300;
        m_dout[MASTER_DBG*DW +: DW] = 8'hAA;
        m_r_nw[MASTER_DBG] = 1'b0;
        tick();
        check("wr_gnt", 32'(m_gnt), 32'h2);
        check("wr_s_a", 32'(s_a), 32'h0200);
        check("wr_s_r_nw", 32'(s_r_nw), 32'h0);
        check("wr_s_din", 32'(s_din), 32'h55);
        m_req = 3'b011;
        tick();
        check("pre_gnt", 32'(m_gnt), 32'h1);
        check("pre_owner", 32'(owner), 32'h0);
        check("pre_s_a", 32'(s_a), 32'h0300);
        check("pre_s_din", 32'(s_din), 32'hAA);
        repeat (6) tick();
        check("dbg_no_limit", 32'(m_gnt), 32'h1);
        m_req = 3'b010;
        tick();
        check("regrant_gnt", 32'(m_gnt), 32'h2);
        check("regrant_s_a", 32'(s_a), 32'h0200);

        // Round-robin, MAX_HOLD=4: CPU owns now (k=0)
        m_req = 3'b110;
        m_a[MASTER_CPU*AW +: AW] = 16'h1111;
        m_a[MASTER_DMA*AW +: AW] = 16'h2222;
        m_r_nw[MASTER_CPU] = 1'b1;
        m_r_nw[MASTER_DMA] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            check("rr_gnt", 32'(m_gnt), ((k / 4) % 2 == 0) ? 32'h2 : 32'h4);
            check("rr_busy", 32'(busy), 32'h1);
            if (k == 4) begin
                check("rr_rv_cpu", 32'(m_rvalid), 32'h2);
                check("rr_din_cpu", 32'(m_din), 32'hB4);
            end
            if (k == 5) begin
                check("rr_rv_dma", 32'(m_rvalid), 32'h4);
                check("rr_din_dma", 32'(m_din), 32'h87);
            end
        end

        // Back-to-back handoff 2 -> 1 (DMA mid-hold)
        m_req = 3'b010;
        m_r_nw[MASTER_DMA] = 1'b0;
        tick();
        check("hand_gnt", 32'(m_gnt), 32'h2);
        check("hand_busy", 32'(busy), 32'h1);
        check("hand_owner", 32'(owner), 32'h1);
        repeat (6) tick();
        check("single_persist", 32'(m_gnt), 32'h2);

        // In-flight CPU read across debugger preemption
        m_a[MASTER_CPU*AW +: AW] = 16'h0140;
        m_r_nw[MASTER_CPU] = 1'b1;
        m_req = 3'b011;
        tick();
        check("inf_gnt", 32'(m_gnt), 32'h1);
        check("inf_rvalid", 32'(m_rvalid), 32'h2);
        check("inf_din", 32'(m_din), 32'hE5);
        tick();
        check("inf_rvalid_after", 32'(m_rvalid), 32'h0);

        // Reset mid-grant
        m_req = 3'b010;
        tick();
        check("mid_gnt", 32'(m_gnt), 32'h2);
        tick();
        check("mid_rvalid", 32'(m_rvalid), 32'h2);
        #1 rst = 1'b0;
        #1;
        check("arst_gnt", 32'(m_gnt), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_s_r_nw", 32'(s_r_nw), 32'h1);
        check("arst_rvalid", 32'(m_rvalid), 32'h0);
        check("arst_owner", 32'(owner), 32'h0);
        m_req = 3'b110;
        #2 rst = 1'b1;
        tick();
        check("post_rst_rr", 32'(m_gnt), 32'h2);
        check("post_rst_rvalid", 32'(m_rvalid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised N-master arbiter for the shared CPU memory-controller bus.
- Generalises the fixed CPU/debugger 2:1 mux into a registered request/grant arbiter.
- Masters are the CPU, the debugger and future DMA engines (OAM DMA, PPU reads).
- Master 0 has absolute priority (debugger). Masters 1..N-1 share the bus by round-robin, with a bounded hold time.
- Read data is returned with a per-master valid strobe, matching the 1-cycle synchronous read latency of cpumc.

Parameters:
- NUM_MASTERS, 3, number of masters (2..8); index 0 is highest priority.
- ADDR_WIDTH, 16, address bus width.
- DATA_WIDTH, 8, data bus width.
- MAX_HOLD, 16, cycles a master ≥1 may hold the grant while another master ≥1 is waiting (≥1).
- RD_LATENCY, 1, slave read latency in cycles (1..2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m_req  in  NUM_MASTERS  per-master bus request; level; held for the whole transaction sequence.
- m_a  in  NUM_MASTERS*ADDR_WIDTH  per-master address; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_r_nw  in  NUM_MASTERS  per-master R/!W.
- m_dout  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
- m_gnt  out  NUM_MASTERS  one-hot grant, registered.
- m_rvalid  out  NUM_MASTERS  per-master read-data-valid strobe.
- m_din  out  DATA_WIDTH  read data, broadcast to all masters.
- s_a  out  ADDR_WIDTH  slave address.
- s_r_nw  out  1  slave R/!W.
- s_din  out  DATA_WIDTH  slave write data.
- s_dout  in  DATA_WIDTH  slave read data.
- owner  out  clog2(NUM_MASTERS)  index of the current grantee; valid when busy=1.
- busy  out  1  grant active.

Behaviour:
- Reset (rst=0, async): m_gnt=0, m_rvalid=0, busy=0, owner=0, rr pointer=1, hold counter=0, rvalid pipeline cleared.
- Slave outputs when idle: s_a=0, s_r_nw=1, s_din=0. The bus never idles as a write.
- FSM has two states, IDLE and OWNED.
- IDLE → OWNED:
  - Any m_req set at edge t gives m_gnt one-hot from t+1.
  - Winner: master 0 if it requests; otherwise the first requester at or after the rr pointer, searching upward with wrap from NUM_MASTERS-1 to 1 (0 skipped).
- OWNED, slave drive:
  - s_a, s_r_nw and s_din are driven combinationally from the owner's inputs every cycle.
  - One access per cycle while granted.
- OWNED, read data:
  - A cycle with owner r_nw=1 at cycle c raises m_rvalid[owner] exactly at c+RD_LATENCY.
  - m_din = s_dout.
  - Strobes are tagged with the owner at issue time, so they still complete after a grant change.
- OWNED → release:
  - If m_req[owner] is low at an edge, the grant drops on that edge.
  - Rearbitration happens on the same edge: a new owner may be granted with no idle cycle.
  - On release of a master ≥1, the rr pointer becomes owner+1, wrapping to 1.
- Preemption by master 0:
  - If master 0 requests while a master ≥1 owns the bus, master 0 takes the grant on the next edge.
  - The preempted master sees m_gnt drop and must stall. It keeps m_req high and resumes when re-granted.
- Hold limit:
  - The counter increments each OWNED cycle for masters ≥1 and resets on any grant change.
  - When it reaches MAX_HOLD-1 and another master ≥1 is requesting, the grant moves to the next round-robin requester.
  - Master 0 is never time-limited. This preserves debug break semantics.
- Edge cases:
  - A master whose m_req is dropped in the same cycle as its grant change never receives a fresh grant.
  - With a single requester, the grant persists indefinitely regardless of the hold counter.
  - Exactly one m_gnt bit is ever set.
  - busy = |m_gnt.
- owner is a binary encoding of m_gnt.

Decomposition:
- Shared package: bus-related constants (NES_ADDR_WIDTH=16, NES_DATA_WIDTH=8) and master index constants (MASTER_DBG=0, MASTER_CPU=1, MASTER_DMA=2). These are shared with the nes top level.
- Sub-module rr_pick: combinational round-robin find-first-set with rotating base, parameterised by width.
- Top level: FSM, hold counter, rvalid shift pipeline and output muxing.

Test Plan:
- Reset mid-grant: CPU owns the bus, rst pulsed low → m_gnt=0, busy=0 and s_r_nw=1 immediately (asynchronous). The rvalid pipeline is flushed.
- Single CPU read: m_req[1]=1, a=0x0123, r_nw=1 → m_gnt=3'b010 next cycle; s_a=0x0123; m_rvalid[1] one cycle later with m_din equal to the slave data.
- Debugger preemption: CPU writes 0x55 to 0x0200 continuously; m_req[0] rises → m_gnt=3'b001 next edge and s_a follows m_a[0]. The CPU is re-granted one edge after m_req[0] falls.
- Round-robin fairness: m_req[1] and m_req[2] held high, MAX_HOLD=4 → grant alternates 1,2,1,… every 4 cycles with no idle cycle between grants.
- Back-to-back handoff: owner 2 drops its request while 1 requests → m_gnt goes 100→010 on one edge and busy stays 1.
- In-flight read across preemption: CPU read issued in the last cycle before debugger preemption → m_rvalid[1] still asserts one cycle later with the correct data. m_rvalid[0] stays 0 for that cycle.
